mux_4_to_1: RTL and testbench

Parameterised 4-input, 1-output data selector with a combinational path and a registered path. The 2-bit `sel` picks one of `d0..d3`. The combinational result is exposed directly, and a one-cycle registered copy is exposed with a valid flag. It is a leaf datapath block used wherever a small operand or route select is needed.

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux_4_to_1_comb.sv | 31 +++
 rtl/mux_4_to_1.sv | 59 +++++
 tb/tb_mux_4_to_1.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and defaults for the 4-to-1 selector.
// Imported by the selector core and the registered top.
package mux_pkg;

    typedef enum logic [1:0] {
        SEL_D0 = 2'b00,
        SEL_D1 = 2'b01,
        SEL_D2 = 2'b10,
        SEL_D3 = 2'b11
    } sel_e;

    localparam int MUX_DEFAULT_WIDTH = 2;

endpackage

// File: rtl/mux_4_to_1_comb.sv
// Pure combinational 4-to-1 selector core.
// An unknown selector yields an unknown result in simulation.
module mux_4_to_1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    sel_e sel_s;

    assign sel_s = sel_e'(sel);

    always_comb begin
        y = 'x;
        unique case (sel_s)
            SEL_D0: y = d0;
            SEL_D1: y = d1;
            SEL_D2: y = d2;
            SEL_D3: y = d3;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_4_to_1.sv
// 4-to-1 selector with a direct output and a one-cycle
// registered copy qualified by out_valid.
module mux_4_to_1
    import mux_pkg::*;
#(
    parameter int               WIDTH   = MUX_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_y;
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    mux_4_to_1_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .sel(sel),
        .y  (sel_y)
    );

    always_comb begin
        data_d  = data_q;
        valid_d = in_valid;
        if (in_valid) begin
            data_d = sel_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= RST_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign y         = sel_y;
    assign y_q       = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_4_to_1.sv
// Self-checking bench: 2-bit and 8-bit instances against
// an array-indexed reference model.
module tb_mux_4_to_1;

    localparam logic [1:0] RST2 = 2'b00;
    localparam logic [7:0] RST8 = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       in_valid;
    logic [1:0] a2 [4];
    logic [7:0] a8 [4];
    logic [1:0] y2, yq2;
    logic [7:0] y8, yq8;
    logic       ov2, ov8;

    logic [1:0] e2;
    logic [7:0] e8;
    logic       ev;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_4_to_1 #(.WIDTH(2), .RST_VAL(RST2)) u2 (
        .clk(clk), .rst(rst),
        .d0(a2[0]), .d1(a2[1]), .d2(a2[2]), .d3(a2[3]),
        .sel(sel), .in_valid(in_valid),
        .y(y2), .y_q(yq2), .out_valid(ov2)
    );

    mux_4_to_1 #(.WIDTH(8), .RST_VAL(RST8)) u8 (
        .clk(clk), .rst(rst),
        .d0(a8[0]), .d1(a8[1]), .d2(a8[2]), .d3(a8[3]),
        .sel(sel), .in_valid(in_valid),
        .y(y8), .y_q(yq8), .out_valid(ov8)
    );

    // Model the edge from the inputs that will be sampled, then step past it.
    task automatic tick();
        if (rst) begin
            e2 = RST2;
            e8 = RST8;
            ev = 1'b0;
        end else begin
            if (in_valid) begin
                e2 = a2[sel];
                e8 = a8[sel];
            end
            ev = in_valid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        sel = 2'b00;
        for (int i = 0; i < 4; i++) begin
            a2[i] = 2'b00;
            a8[i] = 8'h00;
        end
        #1;
        tests++;
        if (yq2 !== RST2 || ov2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_init: y_q=%b ov=%b want %b/0", yq2, ov2, RST2);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        e2 = RST2; e8 = RST8; ev = 1'b0;
        a2[3] = 2'b11;
        a8[3] = 8'hC3;
        sel = 2'b11;
        in_valid = 1'b1;
        tick();
        tests++;
        if (yq2 !== 2'b11 || ov2 !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_cap: y_q=%b ov=%b want 11/1", yq2, ov2);
        end
        in_valid = 1'b0;
        a2[3] = 2'b00;
        a8[3] = 8'h00;
        sel = 2'b00;
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if (yq2 !== RST2 || ov2 !== 1'b0 || y2 !== 2'b00) begin
            fails++;
            $display("FAIL async_reset: y_q=%b ov=%b y=%b want %b/0/00",
                     yq2, ov2, y2, RST2);
        end
        tests++;
        if (yq8 !== RST8 || ov8 !== 1'b0) begin
            fails++;
            $display("FAIL async_reset8: y_q=%h ov=%b want %h/0", yq8, ov8, RST8);
        end
        e2 = RST2; e8 = RST8; ev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_comb_sweep();
        logic [1:0] s;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) a2[i] = 2'(i);
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            sel = s;
            #50;
            tests++;
            if (y2 !== s) begin
                fails++;
                $display("FAIL comb_sweep sel=%b: y=%b want %b", s, y2, s);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [1:0] s;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            sel = s;
            tick();
            tests++;
            if (yq2 !== s || ov2 !== 1'b1) begin
                fails++;
                $display("FAIL capture sel=%b: y_q=%b ov=%b want %b/1",
                         s, yq2, ov2, s);
            end
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (ov2 !== 1'b0 || yq2 !== 2'b11) begin
            fails++;
            $display("FAIL capture_end: y_q=%b ov=%b want 11/0", yq2, ov2);
        end
    endtask

    task automatic test_hold();
        sel = 2'b10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sel = 2'($urandom_range(3));
            for (int i = 0; i < 4; i++) a2[i] = 2'($urandom);
            #1;
            tests++;
            if (y2 !== a2[sel]) begin
                fails++;
                $display("FAIL hold_track: y=%b want %b", y2, a2[sel]);
            end
            tick();
            tests++;
            if (yq2 !== 2'b10 || ov2 !== 1'b0) begin
                fails++;
                $display("FAIL hold: y_q=%b ov=%b want 10/0", yq2, ov2);
            end
        end
    endtask

    task automatic test_reset_priority();
        for (int i = 0; i < 4; i++) a2[i] = 2'(i);
        a8[3] = 8'h81;
        sel = 2'b11;
        in_valid = 1'b1;
        rst = 1'b1;
        tick();
        tests++;
        if (yq2 !== RST2 || ov2 !== 1'b0 || yq8 !== RST8) begin
            fails++;
            $display("FAIL rst_priority: y_q=%b/%h ov=%b want %b/%h/0",
                     yq2, yq8, ov2, RST2, RST8);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (yq2 !== 2'b11 || ov2 !== 1'b1 || yq8 !== 8'h81) begin
            fails++;
            $display("FAIL rst_release_cap: y_q=%b/%h ov=%b want 11/81/1",
                     yq2, yq8, ov2);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_width();
        logic [7:0] want [4];
        want[0] = 8'hA5; want[1] = 8'h3C;
        want[2] = 8'hFF; want[3] = 8'h00;
        for (int i = 0; i < 4; i++) a8[i] = want[i];
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            tests++;
            if (y8 !== want[i]) begin
                fails++;
                $display("FAIL width_y sel=%0d: y=%h want %h", i, y8, want[i]);
            end
            tick();
            tests++;
            if (yq8 !== want[i] || ov8 !== 1'b1) begin
                fails++;
                $display("FAIL width_yq sel=%0d: y_q=%h ov=%b want %h/1",
                         i, yq8, ov8, want[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            sel = 2'($urandom_range(3));
            in_valid = 1'($urandom);
            for (int i = 0; i < 4; i++) begin
                a2[i] = 2'($urandom);
                a8[i] = 8'($urandom);
            end
            #1;
            tests++;
            if (y2 !== a2[sel] || y8 !== a8[sel]) begin
                fails++;
                $display("FAIL rand_y: y=%b/%h want %b/%h",
                         y2, y8, a2[sel], a8[sel]);
            end
            tick();
            tests++;
            if (yq2 !== e2 || yq8 !== e8 || ov2 !== ev || ov8 !== ev) begin
                fails++;
                $display("FAIL rand_reg: y_q=%b/%h ov=%b/%b want %b/%h/%b",
                         yq2, yq8, ov2, ov8, e2, e8, ev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_comb_sweep();
        test_back_to_back();
        test_hold();
        test_reset_priority();
        test_width();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
